// File: rtl/injection_scheduler_pkg.sv
// injection_scheduler_pkg: shared configuration, arbiter state encoding and error bit indices
package injection_scheduler_pkg;
    localparam int CFG_CYLINDERS    = 4;
    localparam int CFG_PW_WIDTH     = 20;
    localparam int CFG_CALC_TIMEOUT = 255;
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam int ERR_NO_PW   = 0;
    localparam int ERR_OVERLAP = 1;
    localparam int ERR_TIMEOUT = 2;
endpackage

// File: rtl/injector_pulse_timer.sv
// injector_pulse_timer: drives one injector for pw cycles after start, then pulses done
module injector_pulse_timer
    import injection_scheduler_pkg::*;
#(
    parameter int PW_WIDTH = CFG_PW_WIDTH
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                on,
    input  logic                start,
    input  logic [PW_WIDTH-1:0] pw,
    output logic                injector,
    output logic                done,
    output logic                busy
);
    logic [PW_WIDTH-1:0] cnt;

    assign busy     = |cnt;
    assign injector = busy;

    // A zero width completes immediately: done on the cycle after start with no pulse
    always_ff @(posedge clk) begin
        if (!reset_n || !on) begin
            cnt  <= '0;
            done <= 1'b0;
        end else if (start && !busy) begin
            cnt  <= pw;
            done <= pw == '0;
        end else begin
            cnt  <= busy ? cnt - 1'b1 : cnt;
            done <= cnt == PW_WIDTH'(1);
        end
    end
endmodule

// File: rtl/injection_scheduler.sv
// injection_scheduler: round-robin access to the shared calculator plus per-cylinder injector pulse timing
module injection_scheduler
    import injection_scheduler_pkg::*;
#(
    parameter int CYLINDERS    = CFG_CYLINDERS,
    parameter int PW_WIDTH     = CFG_PW_WIDTH,
    parameter int CALC_TIMEOUT = CFG_CALC_TIMEOUT
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic [CYLINDERS-1:0]         on,
    input  logic [CYLINDERS-1:0]         cal_req,
    input  logic [CYLINDERS-1:0]         inject,
    output logic                         calc_start,
    output logic [$clog2(CYLINDERS)-1:0] calc_cyl,
    input  logic                         calc_valid,
    input  logic [PW_WIDTH-1:0]          calc_pw,
    output logic [CYLINDERS-1:0]         injector,
    output logic [CYLINDERS-1:0]         done,
    output logic [CYLINDERS-1:0]         pw_ready,
    output logic [2:0]                   err
);
    localparam int CW = $clog2(CYLINDERS);
    localparam int TW = $clog2(CALC_TIMEOUT + 1);

    logic [1:0]           state;
    logic [CW-1:0]        rr_ptr, grant, idx;
    logic [TW-1:0]        wcnt;
    logic                 abort, take;
    logic [CYLINDERS-1:0] pending, busy, start, cyl_mask;
    logic [PW_WIDTH-1:0]  pw_reg [CYLINDERS];

    assign calc_start = state == ST_ISSUE;
    assign cyl_mask   = {{(CYLINDERS-1){1'b0}}, 1'b1} << calc_cyl;
    assign take       = state == ST_WAIT && calc_valid && !abort && on[calc_cyl];
    assign start      = inject & on & ~busy;

    // Scanning downwards lets the nearest pending cylinder at or after rr_ptr win
    always_comb begin
        grant = rr_ptr;
        idx   = rr_ptr;
        for (int k = CYLINDERS - 1; k >= 0; k--) begin
            idx = CW'((int'(rr_ptr) + k) % CYLINDERS);
            if (pending[idx]) grant = idx;
        end
    end

    always_ff @(posedge clk) begin
        if (take) pw_reg[calc_cyl] <= calc_pw;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state    <= ST_IDLE;
            calc_cyl <= '0;
            rr_ptr   <= '0;
            wcnt     <= '0;
            abort    <= 1'b0;
            pending  <= '0;
            pw_ready <= '0;
            err      <= '0;
        end else begin
            pending  <= ((pending & ~(calc_start ? cyl_mask : '0)) | cal_req) & on;
            pw_ready <= ((pw_ready & ~start) | (take ? cyl_mask : '0)) & on;
            if (|(start & ~pw_ready)) err[ERR_NO_PW] <= 1'b1;
            if (|(inject & on & busy)) err[ERR_OVERLAP] <= 1'b1;
            // A cylinder switched off mid-transaction must not receive the late result
            if (state != ST_IDLE && !on[calc_cyl]) abort <= 1'b1;
            case (state)
                ST_IDLE: if (|pending) begin
                    calc_cyl <= grant;
                    abort    <= 1'b0;
                    state    <= ST_ISSUE;
                end
                ST_ISSUE: begin
                    rr_ptr <= (calc_cyl == CW'(CYLINDERS - 1)) ? '0 : calc_cyl + 1'b1;
                    wcnt   <= '0;
                    state  <= ST_WAIT;
                end
                ST_WAIT: if (calc_valid) begin
                    state <= ST_IDLE;
                end else if (wcnt == TW'(CALC_TIMEOUT - 1)) begin
                    err[ERR_TIMEOUT] <= 1'b1;
                    state            <= ST_IDLE;
                end else begin
                    wcnt <= wcnt + 1'b1;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    for (genvar g = 0; g < CYLINDERS; g++) begin : g_cyl
        injector_pulse_timer #(.PW_WIDTH(PW_WIDTH)) u_timer (
            .clk      (clk),
            .reset_n  (reset_n),
            .on       (on[g]),
            .start    (start[g]),
            .pw       (pw_ready[g] ? pw_reg[g] : '0),
            .injector (injector[g]),
            .done     (done[g]),
            .busy     (busy[g])
        );
    end
endmodule

// File: tb/tb_injection_scheduler.sv
// tb_injection_scheduler: directed and random stimulus checked every cycle against a behavioural model
module tb_injection_scheduler;
    localparam int N  = 4;
    localparam int PW = 20;
    localparam int TO = 255;

    logic          clk = 1'b0;
    logic          reset_n, calc_start, calc_valid;
    logic [N-1:0]  on, cal_req, inject, injector, done, pw_ready, on_v;
    logic [1:0]    calc_cyl;
    logic [PW-1:0] calc_pw;
    logic [2:0]    err;
    int compared = 0;
    int mismatched = 0;

    injection_scheduler #(.CYLINDERS(N), .PW_WIDTH(PW), .CALC_TIMEOUT(TO)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .on         (on),
        .cal_req    (cal_req),
        .inject     (inject),
        .calc_start (calc_start),
        .calc_cyl   (calc_cyl),
        .calc_valid (calc_valid),
        .calc_pw    (calc_pw),
        .injector   (injector),
        .done       (done),
        .pw_ready   (pw_ready),
        .err        (err)
    );

    always #5 clk = ~clk;

    // Model: remaining pulse cycles per cylinder, stored widths, and the calculator transaction in flight
    int m_rem [N];
    int m_pw [N];
    bit m_ready [N];
    bit m_pend [N];
    bit m_done [N];
    bit [2:0] m_err;
    int m_cur = -1;
    int m_age, m_rr, m_cyl, m_delay;
    bit m_abort;
    int delay_sel = -1;
    int force_pw = -1;
    bit force_valid = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            if (mismatched <= 20) $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void model_step();
        bit started;
        if (!reset_n) begin
            for (int i = 0; i < N; i++) begin
                m_rem[i] = 0; m_ready[i] = 0; m_pend[i] = 0; m_done[i] = 0;
            end
            m_err = '0; m_cur = -1; m_age = 0; m_rr = 0; m_cyl = 0; m_abort = 0;
            return;
        end
        for (int i = 0; i < N; i++) begin
            started = 0;
            if (!on[i]) begin
                m_rem[i] = 0; m_ready[i] = 0; m_done[i] = 0;
            end else begin
                if (inject[i] && m_rem[i] > 0) m_err[1] = 1;
                else if (inject[i]) begin
                    started = 1;
                    if (!m_ready[i]) m_err[0] = 1;
                    m_rem[i] = m_ready[i] ? m_pw[i] : 0;
                    m_done[i] = m_rem[i] == 0;
                    m_ready[i] = 0;
                end
                if (!started) begin
                    m_done[i] = m_rem[i] == 1;
                    if (m_rem[i] > 0) m_rem[i]--;
                end
            end
        end
        if (m_cur >= 0 && !on[m_cur]) m_abort = 1;
        if (m_cur < 0) begin
            for (int k = 0; k < N; k++) begin
                if (m_pend[(m_rr + k) % N]) begin
                    m_cur = (m_rr + k) % N;
                    break;
                end
            end
            if (m_cur >= 0) begin
                m_age = 0; m_cyl = m_cur; m_abort = 0;
                m_delay = delay_sel >= 0 ? delay_sel :
                          ($urandom_range(15) == 0 ? 1000 : int'($urandom_range(4, 1)));
            end
        end else if (m_age == 0) begin
            m_rr = (m_cur + 1) % N; m_pend[m_cur] = 0; m_age = 1;
        end else if (calc_valid) begin
            if (!m_abort) begin
                m_pw[m_cur] = int'(calc_pw); m_ready[m_cur] = 1;
            end
            m_cur = -1;
        end else if (m_age == TO) begin
            m_err[2] = 1; m_cur = -1;
        end else m_age++;
        for (int i = 0; i < N; i++) m_pend[i] = (m_pend[i] | cal_req[i]) & on[i];
    endfunction

    task automatic check_outputs();
        logic [N-1:0] e_inj, e_done, e_rdy;
        for (int i = 0; i < N; i++) begin
            e_inj[i] = m_rem[i] > 0; e_done[i] = m_done[i]; e_rdy[i] = m_ready[i];
        end
        chk("injector", 32'(injector), 32'(e_inj));
        chk("done", 32'(done), 32'(e_done));
        chk("pw_ready", 32'(pw_ready), 32'(e_rdy));
        chk("err", 32'(err), 32'(m_err));
        chk("calc_start", 32'(calc_start), 32'(m_cur >= 0 && m_age == 0));
        chk("calc_cyl", 32'(calc_cyl), 32'(m_cyl));
    endtask

    task automatic step(input logic rn, input logic [N-1:0] o, input logic [N-1:0] r, input logic [N-1:0] j);
        reset_n = rn; on = o; cal_req = r; inject = j;
        calc_valid = force_valid || (m_cur >= 0 && m_age >= 1 && m_age == m_delay) ||
                     ((m_cur < 0 || m_age == 0) && $urandom_range(15) == 0);
        calc_pw = force_pw >= 0 ? PW'(force_pw) :
                  ($urandom_range(3) == 0 ? '0 : PW'($urandom_range(40, 1)));
        model_step();
        @(negedge clk);
        check_outputs();
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b1, '1, '0, '0);
    endtask

    function automatic logic [N-1:0] rand_mask(input int p);
        logic [N-1:0] m;
        for (int i = 0; i < N; i++) m[i] = $urandom_range(p - 1) == 0;
        return m;
    endfunction

    initial begin
        reset_n = 1'b0; on = '0; cal_req = '0; inject = '0; calc_valid = 1'b0; calc_pw = '0;
        @(negedge clk);
        repeat (3) step(1'b0, '1, '0, '0);
        delay_sel = 2; force_pw = 10;
        step(1'b1, '1, 4'b0100, '0); idle(8);
        step(1'b1, '1, '0, 4'b0100); idle(14);
        delay_sel = 1; force_pw = 0;
        step(1'b1, '1, 4'b1111, '0); idle(16);
        force_pw = -1;
        step(1'b1, '1, 4'b0011, '0); idle(8);
        step(1'b1, '1, '0, 4'b1000); idle(2);
        step(1'b1, '1, '0, 4'b1000); idle(2);
        delay_sel = 1000;
        step(1'b1, '1, 4'b0010, '0);
        step(1'b1, '1, 4'b0001, '0);
        idle(262);
        delay_sel = 1; idle(8);
        force_pw = 100;
        step(1'b1, '1, 4'b0001, '0); idle(6);
        step(1'b1, '1, '0, 4'b0001); idle(19);
        step(1'b1, '1, '0, 4'b0001); idle(85);
        force_pw = 50;
        step(1'b1, '1, 4'b0001, '0); idle(6);
        step(1'b1, '1, '0, 4'b0001); idle(10);
        repeat (2) step(1'b1, 4'b1110, '0, '0);
        idle(5);
        step(1'b1, '1, 4'b0001, '0); idle(6);
        step(1'b1, '1, '0, 4'b0001);
        delay_sel = 1000;
        step(1'b1, '1, 4'b0010, '0); idle(5);
        step(1'b0, '1, '0, '0);
        force_valid = 1'b1;
        step(1'b1, '1, '0, '0);
        force_valid = 1'b0;
        idle(4);
        delay_sel = -1; force_pw = -1; on_v = '1;
        repeat (4000) begin
            for (int i = 0; i < N; i++) if ($urandom_range(199) == 0) on_v[i] = ~on_v[i];
            step($urandom_range(599) != 0, on_v, rand_mask(6), rand_mask(10));
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/injection_scheduler.md
Name: injection_scheduler

Overview:
- Sits between the per-cylinder fuel_injection_control instances and two shared resources: the single injection-time calculation engine and the injector driver outputs.
- Queues each cylinder's cal_injection request and arbitrates the calculator round-robin.
- Latches the returned pulse width per cylinder, then times the injector pulse on each inject request and returns done to the requesting controller.

Parameters:
- CYLINDERS, default `CFG_CYLINDERS (4): number of cylinders/requesters.
- PW_WIDTH, default 20: pulse-width field width, in clk ticks (125 MHz).
- CALC_TIMEOUT, default 255: maximum cycles to wait for calc_valid before abandoning a request.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  reset. Synchronous, active-low. One clock domain only.
- on  in  CYLINDERS  per-cylinder enable (fic_on). Low aborts that cylinder.
- cal_req  in  CYLINDERS  calculation request pulses (fic cal_injection).
- inject  in  CYLINDERS  injection start pulses (fic inject).
- calc_start  out  1  one-cycle start to the calculator.
- calc_cyl  out  $clog2(CYLINDERS)  cylinder index, held from calc_start until the transaction closes.
- calc_valid  in  1  calculator result strobe.
- calc_pw  in  PW_WIDTH  calculated pulse width, sampled when calc_valid=1.
- injector  out  CYLINDERS  injector drive, active high.
- done  out  CYLINDERS  one-cycle injection-complete pulse (to fic done).
- pw_ready  out  CYLINDERS  a latched pulse width is available for that cylinder.
- err  out  3  sticky error flags: {calc_timeout, inject_overlap, inject_no_pw}.

Behaviour:
- Reset (reset_n=0 at posedge):
  - injector, done, pw_ready, calc_start, err, pending and timers all clear to 0.
  - calc_cyl and the RR pointer clear to 0.
  - FSM goes to IDLE.
  - Reset mid-pulse drops injector on the next edge with no done.
- Pending capture: pending[i] sets when cal_req[i]=1 and on[i]=1. It clears when cylinder i is granted. A repeat request while pending or in flight simply (re)sets pending, so it is not lost.
- Arbiter FSM:
  - IDLE: if any pending bit is set, grant the first set bit at or after rr_ptr (wrapping), then go to ISSUE.
  - ISSUE: calc_start=1 for exactly one cycle; calc_cyl=grant; clear pending[grant]; rr_ptr <= grant+1 mod CYLINDERS; go to WAIT.
  - WAIT: count cycles.
    - On calc_valid: pw_reg[calc_cyl] <= calc_pw, pw_ready[calc_cyl] <= 1, go to IDLE.
    - If the count reaches CALC_TIMEOUT first: set err[2], go to IDLE; pw_ready is unchanged.
    - calc_valid outside WAIT is ignored.
  - Minimum spacing between consecutive calc_start pulses is 3 cycles.
- Pulse timer, per cylinder (inject[i] sampled at edge T):
  - If pw_ready[i]=1, pw_reg[i]>0 and the timer is idle:
    - load the counter with pw_reg[i] and clear pw_ready[i] (the width is consumed);
    - injector[i]=1 for cycles T+1 … T+pw;
    - done[i]=1 at T+pw+1 only.
  - If pw_ready[i]=1 and pw_reg[i]=0: no injector pulse, done[i]=1 at T+1, pw_ready cleared.
  - If pw_ready[i]=0: done[i]=1 at T+1 (so the fic does not stall), injector stays low, set err[0].
  - If inject arrives while the timer is active: ignore it, set err[1], the running pulse continues.
- Simultaneous events:
  - calc_valid for cylinder i in the same cycle as inject[i]: inject uses the pre-update pw_ready/pw_reg. The new width is stored and pw_ready=1 afterwards.
  - cal_req and grant of the same cylinder in the same cycle: pending stays set, giving one further calculation.
- on[i]=0, evaluated each cycle:
  - pending[i], pw_ready[i], timer and injector[i] clear next edge; no done.
  - If cylinder i is in WAIT, the result is discarded when it arrives.
- Width rules: counter is PW_WIDTH bits and decrements to 0. Maximum pulse is 2^PW_WIDTH−1 cycles. No saturation is needed.

Decomposition:
- Shared package/defines (hust_efi_defines.vh): CFG_CYLINDERS, CFG_PW_WIDTH, CFG_CALC_TIMEOUT, the arbiter state encoding (IDLE/ISSUE/WAIT) and the err bit indices.
- Sub-module injector_pulse_timer, instantiated per cylinder via a generate loop.
  - Inputs: clk, reset_n, on, start, pw.
  - Outputs: injector, done, busy.
- The arbiter FSM and pending/pw registers stay in the top.

Test Plan:
- Single request: cal_req[2] pulse, calculator returns calc_pw=10 two cycles after calc_start → calc_cyl=2, pw_ready[2]=1. Then inject[2] at T → injector[2] high T+1…T+10, done[2] at T+11, pw_ready[2]=0.
- Round-robin: cal_req=4'b1111 in one cycle, calculator answers each in 1 cycle → calc_start sequence cyl 0,1,2,3. Then cal_req=4'b0011 with rr_ptr=0 → order 0,1.
- Timeout: cal_req[1], calc_valid never asserted → after 255 WAIT cycles err[2]=1, FSM back to IDLE, the next pending request is served.
- Inject without width: inject[3] with pw_ready[3]=0 → done[3] at T+1, injector[3] never high, err[0]=1. Then a zero width (calc_pw=0) → done at T+1, no pulse.
- Overlap/abort: pw=100, inject[0] again at T+20 → ignored, err[1]=1, done at T+101. Separately, on[0] deasserted mid-pulse → injector[0] low next edge, no done.
- Reset mid-operation: reset_n low during WAIT and an active pulse → all outputs 0 on the next edge; a late calc_valid is ignored.
